// File: rtl/featuremap_accumulator_pkg.sv
// Shared FP32 constants and helpers for the featuremap reduction slice.
// Field layout, canonical encodings and a clog2 for sizing.
package featuremap_accumulator_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_EXP_BIAS = 127;

  localparam logic [31:0] FP32_NAN = 32'h7FC00000;
  localparam logic [31:0] FP32_NEG_ZERO = 32'h80000000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F800000;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

endpackage

// File: rtl/featuremap_accumulator_add.sv
// Registered FP32 adder, 1-cycle latency, RNE with flush-to-zero.
// Used for every tree node and for the bias stage.
module fp32_add_reg (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  import featuremap_accumulator_pkg::*;

  logic        sa, sb, za, zb, ia, ib, na, nb;
  logic        swap, sx, sy, sub, rup;
  logic [7:0]  ex, ey, d;
  logic [22:0] mx, my;
  logic [49:0] ys;
  logic [26:0] ax, ay, nrm;
  logic [27:0] raw;
  logic [4:0]  lz;
  logic [9:0]  e;
  logic [30:0] pk;
  logic [31:0] res;

  function automatic logic [4:0] lzc(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  always_comb begin
    sa = a[31];
    sb = b[31];
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    na = is_nan(a);
    nb = is_nan(b);
    swap = b[30:0] > a[30:0];
    {sx, ex, mx} = swap ? b : a;
    {sy, ey, my} = swap ? a : b;
    sub = sx ^ sy;
    d = ex - ey;
    // sticky collapses everything shifted past the round bit
    ys = {1'b1, my, 26'b0} >> d;
    ay = (d > 8'd26) ? 27'd1 : {ys[49:24], |ys[23:0]};
    ax = {1'b1, mx, 3'b000};
    raw = sub ? ({1'b0, ax} - {1'b0, ay})
              : ({1'b0, ax} + {1'b0, ay});
    lz = lzc(raw[26:0]);
    if (raw[27]) begin
      nrm = {raw[27:2], raw[1] | raw[0]};
      e = {2'b00, ex} + 10'd1;
    end else begin
      nrm = raw[26:0] << lz;
      e = {2'b00, ex} - {5'b0, lz};
    end
    rup = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    // mantissa carry ripples into the exponent, reaching Inf at 254
    pk = {e[7:0], nrm[25:3]} + 31'(rup);
    res = '0;
    if (na || nb || (ia && ib && (sa != sb)))
      res = FP32_NAN;
    else if (ia)
      res = a;
    else if (ib)
      res = b;
    else if (za && zb)
      res = {sa & sb, 31'b0};
    else if (za)
      res = b;
    else if (zb)
      res = a;
    else if (!nrm[26])
      res = '0;
    else if (e[9] || (e == 10'd0))
      res = {sx, 31'b0};
    else if (e >= 10'd255)
      res = {sx, FP32_POS_INF[30:0]};
    else
      res = {sx, pk};
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) sum <= '0;
    else      sum <= res;
  end

endmodule

// File: rtl/featuremap_accumulator.sv
// Per-featuremap channel reduction: adder tree, bias, leaky activation,
// plus frame pixel counting and a sticky NaN indicator.
module featuremap_accumulator #(
  parameter int          NUM_CH      = 32,
  parameter int          IMG_SIZE    = 104,
  parameter logic [31:0] BIAS        = 32'h00000000,
  parameter int          ACT_MODE    = 1,
  parameter int          LEAKY_SHIFT = 3
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [NUM_CH*32-1:0] data_in,
  input  logic                valid_in,
  output logic [31:0]         data_out,
  output logic                valid_out,
  output logic                frame_done,
  output logic                nan_flag
);
  import featuremap_accumulator_pkg::*;

  localparam int LV = clog2(NUM_CH);
  localparam int L = LV + 2;
  localparam int FRAME = IMG_SIZE * IMG_SIZE;
  localparam int CW = clog2(FRAME + 1);
  localparam logic [7:0] SHIFT = 8'(LEAKY_SHIFT);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [31:0]       t [1:2*NUM_CH-1];
  logic [NUM_CH-1:1] nan_hit;
  logic [L-2:0]      vsr;
  logic [31:0]       biased, act;
  logic [CW-1:0]     cnt;
  logic              nan_seen, nan_now;

  // heap layout: node j sums children 2j and 2j+1, leaves at NUM_CH+i
  for (genvar i = 0; i < NUM_CH; i++) begin : g_leaf
    assign t[NUM_CH + i] = data_in[32*i +: 32];
  end

  for (genvar j = 1; j < NUM_CH; j++) begin : g_node
    localparam int K = LV + 1 - clog2(j + 1);
    fp32_add_reg u_add (
      .Clk (Clk),
      .Rst (Rst),
      .a   (t[2*j]),
      .b   (t[2*j+1]),
      .sum (t[j])
    );
    assign nan_hit[j] = vsr[K-1] & is_nan(t[j]);
  end

  fp32_add_reg u_bias (
    .Clk (Clk),
    .Rst (Rst),
    .a   (t[1]),
    .b   (BIAS),
    .sum (biased)
  );

  always_comb begin
    act = biased;
    if (is_nan(biased))
      act = FP32_NAN;
    else if ((ACT_MODE != 0) && biased[31] && (biased[30:23] != 8'hFF)) begin
      if (biased[30:23] > SHIFT)
        act = {1'b1, biased[30:23] - SHIFT, biased[22:0]};
      else
        act = FP32_NEG_ZERO;
    end
  end

  assign nan_now = (|nan_hit)
                 | (vsr[L-2] & is_nan(biased))
                 | (valid_out & is_nan(data_out));
  assign nan_flag = nan_seen | nan_now;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vsr        <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
      cnt        <= '0;
      nan_seen   <= 1'b0;
    end else begin
      vsr        <= {vsr[L-3:0], valid_in};
      valid_out  <= vsr[L-2];
      data_out   <= act;
      frame_done <= vsr[L-2] && (cnt == LAST);
      if (vsr[L-2])
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      if (nan_now)
        nan_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_featuremap_accumulator.sv
// Bench for featuremap_accumulator: directed FP corner cases plus random
// integer-valued lanes checked against a real-arithmetic reference.
module tb_featuremap_accumulator;

  localparam int N = 32;
  localparam int IMG = 2;
  localparam int LAT = 7;
  localparam int W = N * 32;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    logic        fd;
  } item_t;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         valid_in = 1'b0;
  logic [31:0]  data_out;
  logic         valid_out, frame_done, nan_flag;

  item_t exp_q[$];
  item_t obs_q[$];
  real   lv[N];
  int    cyc = 0;
  int    seq = 0;
  int    checks = 0;
  int    passed = 0;
  int    bad_fd = 0;

  featuremap_accumulator #(
    .NUM_CH      (N),
    .IMG_SIZE    (IMG),
    .BIAS        (32'h3F000000),
    .ACT_MODE    (1),
    .LEAKY_SHIFT (3)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .frame_done (frame_done),
    .nan_flag   (nan_flag)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    item_t it;
    if (Rst) begin
      if (valid_out) begin
        it.data = data_out;
        it.cyc = cyc;
        it.fd = frame_done;
        obs_q.push_back(it);
      end else if (frame_done) begin
        bad_fd++;
      end
    end
  end

  // exact values only: double bits repacked into single precision
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
  endfunction

  function automatic logic [31:0] model();
    real s;
    s = 0.5;
    for (int i = 0; i < N; i++) s += lv[i];
    if (s < 0.0) s = s / 8.0;
    return r2f(s);
  endfunction

  function automatic logic [W-1:0] pack_lv();
    logic [W-1:0] d;
    for (int i = 0; i < N; i++) d[32*i +: 32] = r2f(lv[i]);
    return d;
  endfunction

  function automatic logic [W-1:0] fill(input logic [31:0] x);
    return {N{x}};
  endfunction

  task automatic rand_lv();
    for (int i = 0; i < N; i++)
      lv[i] = real'(int'($urandom_range(0, 2000)) - 1000)
            / real'(1 << $urandom_range(0, 4));
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d,
                       input logic [31:0] e);
    item_t it;
    data_in = d;
    valid_in = v;
    if (v) begin
      it.data = e;
      it.cyc = cyc;
      it.fd = (seq % (IMG * IMG)) == (IMG * IMG - 1);
      exp_q.push_back(it);
      seq++;
    end
    @(posedge Clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
    obs_q.delete();
    seq = 0;
    idle(2);
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge Clk);
    checks++;
    if (valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_out);
    else passed++;
    checks++;
    if (frame_done !== 1'b0) $display("FAIL reset_fd got %b want 0", frame_done);
    else passed++;
    checks++;
    if (nan_flag !== 1'b0) $display("FAIL reset_nan got %b want 0", nan_flag);
    else passed++;
    checks++;
    if (data_out !== 32'h0) $display("FAIL reset_data got %h want 0", data_out);
    else passed++;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_single();
    logic [W-1:0] d;
    item_t o, e;
    drive(1'b1, fill(32'h3F800000), 32'h42020000);
    drive(1'b1, fill(32'hBF800000), 32'hC07C0000);
    d = '0;
    d[31:0] = 32'h4B800000;
    d[63:32] = 32'h3F800000;
    drive(1'b1, d, 32'h4B800000);
    d[63:32] = 32'h40400000;
    drive(1'b1, d, 32'h4B800002);
    d[31:0] = 32'h7F7FFFFF;
    d[63:32] = 32'h7F7FFFFF;
    drive(1'b1, d, 32'h7F800000);
    idle(LAT + 3);
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.cyc !== e.cyc + LAT || o.fd !== e.fd)
        $display("FAIL single got %h @%0d fd=%b want %h @%0d fd=%b",
                 o.data, o.cyc, o.fd, e.data, e.cyc + LAT, e.fd);
      else passed++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    item_t o, e;
    for (int i = 0; i < 8; i++) drive(1'b1, '0, 32'h3F000000);
    for (int i = 0; i < 16; i++) drive(i % 2 == 1, '0, 32'h3F000000);
    idle(LAT + 3);
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.cyc !== e.cyc + LAT || o.fd !== e.fd)
        $display("FAIL b2b got %h @%0d fd=%b want %h @%0d fd=%b",
                 o.data, o.cyc, o.fd, e.data, e.cyc + LAT, e.fd);
      else passed++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    item_t o, e;
    for (int i = 0; i < 60; i++) begin
      rand_lv();
      drive($urandom_range(0, 3) != 0, pack_lv(), model());
    end
    idle(LAT + 3);
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.cyc !== e.cyc + LAT || o.fd !== e.fd)
        $display("FAIL rand got %h @%0d fd=%b want %h @%0d fd=%b",
                 o.data, o.cyc, o.fd, e.data, e.cyc + LAT, e.fd);
      else passed++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_frame();
    item_t o, e;
    int nfd;
    do_reset();
    nfd = 0;
    for (int i = 0; i < 12; i++) begin
      rand_lv();
      drive(1'b1, pack_lv(), model());
    end
    idle(LAT + 3);
    checks++;
    if (obs_q.size() !== 12)
      $display("FAIL frame_count got %0d want 12", obs_q.size());
    else passed++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o.fd) nfd++;
      checks++;
      if (o.data !== e.data || o.cyc !== e.cyc + LAT || o.fd !== e.fd)
        $display("FAIL frame got %h @%0d fd=%b want %h @%0d fd=%b",
                 o.data, o.cyc, o.fd, e.data, e.cyc + LAT, e.fd);
      else passed++;
    end
    checks++;
    if (nfd !== 3) $display("FAIL frame_pulses got %0d want 3", nfd);
    else passed++;
    checks++;
    if (bad_fd !== 0) $display("FAIL fd_on_bubble got %0d want 0", bad_fd);
    else passed++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_nan();
    logic [W-1:0] d;
    item_t o, e;
    checks++;
    if (nan_flag !== 1'b0) $display("FAIL nan_pre got %b want 0", nan_flag);
    else passed++;
    d = fill(32'h3F800000);
    d[5*32 +: 32] = 32'h7F800001;
    drive(1'b1, d, 32'h7FC00000);
    @(negedge Clk);
    checks++;
    if (nan_flag !== 1'b1) $display("FAIL nan_rise got %b want 1", nan_flag);
    else passed++;
    @(posedge Clk);
    #1;
    d = '0;
    d[31:0] = 32'h7F800000;
    d[63:32] = 32'hFF800000;
    drive(1'b1, d, 32'h7FC00000);
    for (int i = 0; i < 6; i++) begin
      rand_lv();
      drive(1'b1, pack_lv(), model());
    end
    idle(LAT + 3);
    checks++;
    if (nan_flag !== 1'b1) $display("FAIL nan_sticky got %b want 1", nan_flag);
    else passed++;
    checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL nan_count got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.cyc !== e.cyc + LAT || o.fd !== e.fd)
        $display("FAIL nan got %h @%0d fd=%b want %h @%0d fd=%b",
                 o.data, o.cyc, o.fd, e.data, e.cyc + LAT, e.fd);
      else passed++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midburst();
    item_t o, e;
    for (int i = 0; i < 9; i++) begin
      rand_lv();
      drive(1'b1, pack_lv(), model());
    end
    checks++;
    if (valid_out !== 1'b1) $display("FAIL burst_live got %b want 1", valid_out);
    else passed++;
    valid_in = 1'b1;
    Rst = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0) $display("FAIL async_valid got %b want 0", valid_out);
    else passed++;
    checks++;
    if (frame_done !== 1'b0) $display("FAIL async_fd got %b want 0", frame_done);
    else passed++;
    checks++;
    if (nan_flag !== 1'b0) $display("FAIL async_nan got %b want 0", nan_flag);
    else passed++;
    do_reset();
    idle(LAT + 5);
    checks++;
    if (obs_q.size() !== 0) $display("FAIL stale_out got %0d want 0", obs_q.size());
    else passed++;
    obs_q.delete();
    drive(1'b1, fill(32'h3F800000), 32'h42020000);
    idle(LAT + 3);
    checks++;
    if (obs_q.size() !== 1)
      $display("FAIL post_count got %0d want 1", obs_q.size());
    else passed++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.cyc !== e.cyc + LAT || o.fd !== e.fd)
        $display("FAIL post got %h @%0d fd=%b want %h @%0d fd=%b",
                 o.data, o.cyc, o.fd, e.data, e.cyc + LAT, e.fd);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_frame();
    test_nan();
    test_reset_midburst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/featuremap_accumulator.md
Name: featuremap_accumulator

Overview:
Per-output-featuremap reduction stage for the YOLOv3Tiny conv layers. It takes the NUM_CH per-input-channel Conv2D3x3 partial results for one pixel and sums them in a pipelined FP32 adder tree. It then adds the featuremap bias and applies an optional leaky activation. It also counts output pixels and flags end of frame, so a layer_N_featuremap_M wrapper needs only its Conv2D3x3 instances plus this block.

Parameters:
NUM_CH, 32, number of input channel lanes; power of 2, range 2..1024
IMG_SIZE, 104, output featuremap width/height in pixels; frame = IMG_SIZE*IMG_SIZE outputs
BIAS, 32'h00000000, FP32 bias added after the reduction
ACT_MODE, 1, 0 = linear, 1 = leaky
LEAKY_SHIFT, 3, negative slope = 2^-LEAKY_SHIFT; range 1..8

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
data_in  in  NUM_CH*32  lane i = data_in[32i+31:32i], FP32
valid_in  in  1  qualifies all lanes of data_in this cycle
data_out  out  32  FP32 activated featuremap pixel
valid_out  out  1  qualifies data_out
frame_done  out  1  one-cycle pulse, coincident with the last valid_out of a frame
nan_flag  out  1  sticky; set when any stage produces or receives NaN

Behaviour:
- Reset (Rst low, asynchronous): all pipeline data registers, valid_out, frame_done, nan_flag and pixel counter go to 0. Any valid in flight is discarded. There is no output for samples accepted before reset.
- Streaming, no backpressure: the pipeline advances every cycle. valid_in may drop on any cycle, and bubbles propagate unchanged through a valid shift register.
- Latency L = log2(NUM_CH) + 2 cycles from valid_in to valid_out. Default: 5 tree levels, 1 bias stage, 1 activation stage, so L = 7.
- Tree level k adds adjacent pairs from level k-1. Ordering is fixed: level-0 pair j = lanes (2j, 2j+1). This keeps results bit-exact and reproducible.
- Bias stage: sum + BIAS.
- Activation stage:
  - ACT_MODE = 0, or sign bit clear: pass through.
  - Negative finite value with exponent e: if e > LEAKY_SHIFT, the output exponent is e-LEAKY_SHIFT and sign and mantissa are unchanged. Otherwise the output is -0 (0x80000000).
  - -Inf passes through unchanged. NaN passes through as canonical 0x7FC00000.
- FP32 add rules (all stages): round-to-nearest-even. Subnormal inputs and results flush to signed zero. Overflow gives ±Inf. Inf + (-Inf) gives canonical NaN. Any NaN input gives canonical NaN.
- nan_flag: set on the cycle a NaN is registered at any stage with its valid set. Cleared only by reset.
- Pixel counter: increments on each valid_out; range 0..IMG_SIZE²-1.
  - On the valid_out where count = IMG_SIZE²-1, frame_done = 1 and the counter wraps to 0.
  - frame_done is 0 on all other cycles, including bubbles.
- data_out holds the value of the last stage register. It is meaningful only while valid_out = 1.

Decomposition:
- Shared package: FP32 field widths (sign, 8-bit exponent, 23-bit mantissa), exponent bias 127, FP32_NAN = 32'h7FC00000, FP32_NEG_ZERO, and a clog2 helper function.
- One sub-module, fp32_add_reg: a registered FP32 adder with 1-cycle latency, implementing the add rules above.
  - Instantiated NUM_CH-1 times in the generate tree, plus once for the bias stage.
  - The activation stage and counter are inline.

Test Plan:
1. NUM_CH=32, BIAS=0: all lanes 0x3F800000 (1.0), one valid_in pulse -> exactly one valid_out 7 cycles later with data_out = 0x42000000 (32.0).
2. ACT_MODE=1, LEAKY_SHIFT=3: all lanes 0xBF800000 (-1.0) -> data_out = 0xC0800000 (-4.0). With ACT_MODE=0 -> 0xC2000000.
3. BIAS=0x3F000000, all lanes 0, eight back-to-back valids followed by bubbles at alternate cycles -> 0x3F000000 on each valid_out. valid_out pattern equals valid_in pattern delayed 7 cycles.
4. IMG_SIZE=2, continuous valid_in -> frame_done high on the 4th, 8th and 12th valid_out only; counter wraps cleanly.
5. Lane 5 = 0x7F800001 (NaN), others 1.0 -> data_out = 0x7FC00000 and nan_flag rises and stays high through later clean samples until Rst is asserted.
6. Rst pulsed low 3 cycles after a valid_in burst starts -> valid_out, frame_done and nan_flag are 0 immediately (asynchronous). No stale output after release, and the first post-reset sample appears L cycles after its valid_in.
